// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction codes, FSM states, grid geometry
// and the small helpers used by the movement engine.
package snake_pkg;

    localparam int GRID_W = 8;
    localparam int GRID_H = 8;
    localparam int IDX_W  = 6;
    localparam int SLOT_N = 8;
    localparam int COL_W  = $clog2(GRID_W);
    localparam int ROW_W  = $clog2(GRID_H);

    // Codes match the encoder's ges_pic map.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    // Opposite directions differ only in bit 0.
    function automatic dir_t dir_reverse(input dir_t d);
        return dir_t'(d ^ 2'd1);
    endfunction

    function automatic logic ges_valid(input logic [3:0] g);
        return (g == 4'b0001) || (g == 4'b0010) || (g == 4'b0100) || (g == 4'b1000);
    endfunction

    function automatic dir_t ges_to_dir(input logic [3:0] g);
        case (g)
            4'b0001: return DIR_UP;
            4'b0010: return DIR_DOWN;
            4'b0100: return DIR_LEFT;
            default: return DIR_RIGHT;
        endcase
    endfunction

    // Row/column arithmetic stays inside its own bit width, so walls wrap for free.
    function automatic logic [IDX_W-1:0] next_cell(input logic [IDX_W-1:0] c, input dir_t d);
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        row = c[IDX_W-1:COL_W];
        col = c[COL_W-1:0];
        case (d)
            DIR_UP:   row = row - 1'b1;
            DIR_DOWN: row = row + 1'b1;
            DIR_LEFT: col = col - 1'b1;
            default:  col = col + 1'b1;
        endcase
        return {row, col};
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Movement step timer: counts STEP_CYCLES clocks while enabled and emits a one-cycle
// registered tick each time the count wraps.
module snake_step_timer #(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake movement engine: gesture-to-direction, one-cell steps with wall wrap, growth,
// self-collision detection and the packed segment list for the LED frame encoder.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int STEP_CYCLES = 12_500_000,
    parameter int INIT_LEN    = 4,
    parameter int INIT_HEAD   = 27,
    parameter int MAX_LEN     = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [3:0]              ges_data,
    input  logic                    grow,
    input  logic                    restart,
    output logic [IDX_W*SLOT_N-1:0] index_data,
    output logic [3:0]              snake_len,
    output logic                    game_over,
    output logic                    step_pulse
);

    localparam logic [3:0] INIT_L = 4'(INIT_LEN);
    localparam logic [3:0] MAX_L  = 4'(MAX_LEN);

    function automatic logic [IDX_W-1:0] init_slot(input int k);
        return (k < INIT_LEN) ? IDX_W'(INIT_HEAD - k) : IDX_W'(INIT_HEAD - INIT_LEN + 1);
    endfunction

    state_t           state;
    dir_t             dir;
    dir_t             dir_next;
    logic             grow_pend;
    logic [IDX_W-1:0] slots [SLOT_N];

    logic             tick;
    logic             step;
    logic             ges_ok;
    dir_t             ges_dir;
    logic [IDX_W-1:0] head_new;
    logic             growing;
    logic [3:0]       len_new;
    logic [2:0]       last_idx;
    logic             collide;
    logic [IDX_W-1:0] shifted   [SLOT_N];
    logic [IDX_W-1:0] slots_new [SLOT_N];

    snake_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .en    (state == ST_RUN),
        .clr   ((state != ST_RUN) || restart),
        .tick  (tick)
    );

    assign step     = tick && (state == ST_RUN);
    assign ges_ok   = ges_valid(ges_data);
    assign ges_dir  = ges_to_dir(ges_data);
    assign head_new = next_cell(slots[0], dir_next);
    assign growing  = grow_pend && (snake_len < MAX_L);
    assign len_new  = snake_len + {3'b000, growing};
    assign last_idx = 3'(len_new - 4'd1);

    // The tail slot vacates this step unless the snake grows, so it is not a hazard.
    always_comb begin
        collide = 1'b0;
        for (int k = 0; k < SLOT_N; k++) begin
            if ((4'(k) < snake_len) && ((4'(k) != snake_len - 4'd1) || growing)
                && (slots[k] == head_new))
                collide = 1'b1;
        end
    end

    always_comb begin
        shifted    = slots;
        slots_new  = slots;
        shifted[0] = head_new;
        for (int k = 1; k < SLOT_N; k++)
            shifted[k] = slots[k-1];
        for (int k = 0; k < SLOT_N; k++)
            slots_new[k] = (4'(k) < len_new) ? shifted[k] : shifted[last_idx];
    end

    always_comb begin
        index_data = '0;
        for (int k = 0; k < SLOT_N; k++)
            index_data[IDX_W*k +: IDX_W] = slots[k];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            dir        <= DIR_RIGHT;
            dir_next   <= DIR_RIGHT;
            grow_pend  <= 1'b0;
            snake_len  <= INIT_L;
            game_over  <= 1'b0;
            step_pulse <= 1'b0;
            for (int k = 0; k < SLOT_N; k++) slots[k] <= init_slot(k);
        end else if (restart) begin
            state      <= ST_IDLE;
            dir        <= DIR_RIGHT;
            dir_next   <= DIR_RIGHT;
            grow_pend  <= 1'b0;
            snake_len  <= INIT_L;
            game_over  <= 1'b0;
            step_pulse <= 1'b0;
            for (int k = 0; k < SLOT_N; k++) slots[k] <= init_slot(k);
        end else begin
            step_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grow) grow_pend <= 1'b1;
                    if (ges_ok && (ges_dir != dir_reverse(dir))) begin
                        dir      <= ges_dir;
                        dir_next <= ges_dir;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step) begin
                        if (collide) begin
                            state     <= ST_DEAD;
                            game_over <= 1'b1;
                        end else begin
                            slots      <= slots_new;
                            snake_len  <= len_new;
                            dir        <= dir_next;
                            step_pulse <= 1'b1;
                            // A grow arriving on the step edge carries over to the next step.
                            grow_pend  <= grow;
                            if (ges_ok && (ges_dir != dir_reverse(dir_next)))
                                dir_next <= ges_dir;
                        end
                    end else begin
                        if (grow) grow_pend <= 1'b1;
                        if (ges_ok && (ges_dir != dir_reverse(dir)))
                            dir_next <= ges_dir;
                    end
                end
                ST_DEAD: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl with a 4-cycle step: table-driven move sequence plus
// hand-written restart, collision and async-reset sequences, checked by a step scoreboard.
module tb_snake_move_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [3:0]  ges_data = 4'b0000;
    logic        grow = 1'b0;
    logic        restart = 1'b0;
    logic [47:0] index_data;
    logic [3:0]  snake_len;
    logic        game_over;
    logic        step_pulse;

    snake_move_ctrl #(
        .STEP_CYCLES (4),
        .INIT_LEN    (4),
        .INIT_HEAD   (27),
        .MAX_LEN     (8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .ges_data   (ges_data),
        .grow       (grow),
        .restart    (restart),
        .index_data (index_data),
        .snake_len  (snake_len),
        .game_over  (game_over),
        .step_pulse (step_pulse)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [5:0]  m_body[$];
    int          m_len;
    logic [51:0] exp_q[$];
    logic [51:0] mon_exp;

    task automatic m_init();
        m_body.delete();
        for (int k = 0; k < 4; k++) m_body.push_back(6'(27 - k));
        m_len = 4;
    endtask

    function automatic logic [47:0] m_pack();
        logic [47:0] w;
        w = '0;
        for (int k = 0; k < 8; k++)
            w[6*k +: 6] = (k < m_len) ? m_body[k] : m_body[m_len-1];
        return w;
    endfunction

    task automatic m_step(input logic [5:0] head, input logic g);
        m_body.push_front(head);
        if (g && m_len < 8) m_len++;
        else void'(m_body.pop_back());
    endtask

    task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge sys_clk) begin
        if (sys_rst_n && step_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_step: got index %h len %0d, expected no step", index_data, snake_len);
            end else begin
                mon_exp = exp_q.pop_front();
                check("step_scoreboard", {snake_len, index_data}, mon_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick_n(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_ges(input logic [3:0] g, input logic gr);
        ges_data = g;
        grow = gr;
        @(negedge sys_clk);
        ges_data = 4'b0000;
        grow = 1'b0;
    endtask

    task automatic wait_step(output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (step_pulse === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL step_timeout: got no step_pulse in 20 cycles, expected one");
        end
    endtask

    task automatic apply_row(input logic [3:0] g1, input logic [3:0] g2, input logic gr,
                             input logic [5:0] head, input logic [3:0] len,
                             input string tag, output int at);
        m_step(head, gr);
        exp_q.push_back({4'(m_len), m_pack()});
        pulse_ges(g1, gr);
        if (g2 != 4'b0000) pulse_ges(g2, 1'b0);
        wait_step(at);
        check({tag, "_head"}, 52'(index_data[5:0]), 52'(head));
        check({tag, "_len"}, 52'(snake_len), 52'(len));
    endtask

    task automatic check_init(input string tag);
        m_init();
        check({tag, "_index"}, 52'(index_data), 52'(m_pack()));
        check({tag, "_len"}, 52'(snake_len), 52'(4));
        check({tag, "_game_over"}, 52'(game_over), 52'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] g1;
        logic [3:0] g2;
        logic       gr;
        logic [5:0] head;
        logic [3:0] len;
    } vec_t;

    vec_t tab[15];

    initial begin
        int at;
        int at0;

        tab[0]  = '{4'b0000, 4'b0000, 1'b0, 6'd28, 4'd4};
        tab[1]  = '{4'b0000, 4'b0000, 1'b0, 6'd29, 4'd4};
        tab[2]  = '{4'b0100, 4'b0000, 1'b0, 6'd30, 4'd4};  // reversal ignored
        tab[3]  = '{4'b0000, 4'b0000, 1'b0, 6'd31, 4'd4};
        tab[4]  = '{4'b0000, 4'b0000, 1'b0, 6'd24, 4'd4};  // column wrap
        tab[5]  = '{4'b0001, 4'b0100, 1'b0, 6'd16, 4'd4};  // up then left: up kept
        tab[6]  = '{4'b0100, 4'b0000, 1'b0, 6'd23, 4'd4};  // left after up, wraps
        tab[7]  = '{4'b0001, 4'b0000, 1'b0, 6'd15, 4'd4};
        tab[8]  = '{4'b0000, 4'b0000, 1'b0, 6'd7,  4'd4};
        tab[9]  = '{4'b0000, 4'b0000, 1'b0, 6'd63, 4'd4};  // row wrap
        tab[10] = '{4'b0000, 4'b0000, 1'b1, 6'd55, 4'd5};
        tab[11] = '{4'b0000, 4'b0000, 1'b1, 6'd47, 4'd6};
        tab[12] = '{4'b0000, 4'b0000, 1'b1, 6'd39, 4'd7};
        tab[13] = '{4'b0000, 4'b0000, 1'b1, 6'd31, 4'd8};
        tab[14] = '{4'b0000, 4'b0000, 1'b1, 6'd23, 4'd8};  // saturated; head into tail cell

        // Reset state
        sys_rst_n = 1'b0;
        tick_n(2);
        sys_rst_n = 1'b1;
        check_init("reset");
        check("reset_step_pulse", 52'(step_pulse), 52'(0));

        // IDLE holds; LEFT cannot start the game
        tick_n(6);
        pulse_ges(4'b0100, 1'b0);
        tick_n(8);
        check("idle_left_ignored", 52'(index_data), 52'(m_pack()));

        // Run A: table-driven moves, wraps, reversal guard, growth to saturation
        pulse_ges(4'b1000, 1'b0);
        at0 = 0;
        for (int i = 0; i < 15; i++) begin
            apply_row(tab[i].g1, tab[i].g2, tab[i].gr, tab[i].head, tab[i].len,
                      $sformatf("row%0d", i), at);
            if (i == 0) at0 = at;
            if (i == 1) check("step_interval", 52'(at - at0), 52'(4));
        end

        // Restart on the tick cycle beats the step
        tick_n(3);
        restart = 1'b1;
        @(negedge sys_clk);
        restart = 1'b0;
        check_init("restart_tick");
        tick_n(10);
        check("restart_idle_hold", 52'(index_data), 52'(m_pack()));

        // Run B: square at length 4, head enters the tail cell safely
        pulse_ges(4'b1000, 1'b0);
        apply_row(4'b0000, 4'b0000, 1'b0, 6'd28, 4'd4, "sq_right", at);
        apply_row(4'b0010, 4'b0000, 1'b0, 6'd36, 4'd4, "sq_down", at);
        apply_row(4'b0100, 4'b0000, 1'b0, 6'd35, 4'd4, "sq_left", at);
        apply_row(4'b0001, 4'b0000, 1'b0, 6'd27, 4'd4, "sq_up_tail", at);
        apply_row(4'b1000, 4'b0000, 1'b0, 6'd28, 4'd4, "sq_right2", at);

        restart = 1'b1;
        @(negedge sys_clk);
        restart = 1'b0;
        check_init("restart_b");

        // Run C: length 5 square runs into its own body
        pulse_ges(4'b1000, 1'b0);
        apply_row(4'b0000, 4'b0000, 1'b1, 6'd28, 4'd5, "col_grow", at);
        apply_row(4'b0010, 4'b0000, 1'b0, 6'd36, 4'd5, "col_down", at);
        apply_row(4'b0100, 4'b0000, 1'b0, 6'd35, 4'd5, "col_left", at);
        pulse_ges(4'b0001, 1'b0);
        tick_n(10);
        check("dead_game_over", 52'(game_over), 52'(1));
        check("dead_index_frozen", 52'(index_data), 52'(m_pack()));
        check("dead_len", 52'(snake_len), 52'(5));
        pulse_ges(4'b1000, 1'b1);
        tick_n(10);
        check("dead_ignores_input", {snake_len, index_data}, {4'(m_len), m_pack()});
        check("dead_step_pulse", 52'(step_pulse), 52'(0));

        restart = 1'b1;
        @(negedge sys_clk);
        restart = 1'b0;
        check_init("restart_dead");

        // Async reset in the middle of a step interval
        pulse_ges(4'b1000, 1'b0);
        apply_row(4'b0000, 4'b0000, 1'b0, 6'd28, 4'd4, "async_pre", at);
        tick_n(1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check_init("async_reset");
        check("async_step_pulse", 52'(step_pulse), 52'(0));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick_n(10);
        check("async_idle_hold", 52'(index_data), 52'(m_pack()));

        check("scoreboard_drained", 52'(exp_q.size()), 52'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
